depth_sprite: RTL and testbench
===============================

DEPTH_SPRITE -- requirements
Module: depth_sprite

Interface
REQ-001 SHALL expose parameters (name, default, meaning):
- COORD_W, 16, screen coordinate and location width
- COLOR_W, 24, pixel colour width
- NUM_ZONES, 20, number of depth zones / sprite scales
- ZONE_STEP, 50, z_loc units per zone
- ADDR_W, 14, shared sprite ROM address width
- KEY_HI/KEY_LO, 15/8, colour bit field tested for transparency
- KEY_THRESH, 8'h90, minimum key value for an opaque pixel
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, asynchronous active-low reset
- frame_start, in, 1, one-cycle pulse before first pixel of a frame
- pix_valid, in, 1, pixel_x/pixel_y valid this cycle
- pixel_x, pixel_y, in, COORD_W, current raster position
- x_loc, y_loc, z_loc, in, COORD_W, sprite top-left and depth
- rom_addr, out, ADDR_W, address to external synchronous ROM (1-cycle read latency)
- rom_data, in, COLOR_W, ROM read data
- color, out, COLOR_W, sprite pixel or 0
- color_valid, out, 1, color corresponds to a pix_valid input
- active, out, 1, sprite pixel opaque and in box

Function
REQ-003 SHALL latch x_loc, y_loc, z_loc on frame_start only; mid-frame input changes have no effect until the next frame_start.
REQ-004 SHALL compute zone = min(z_loc / ZONE_STEP, NUM_ZONES-1), registered on frame_start; z_loc beyond the last zone clamps.
REQ-005 SHALL take sprite side N and ROM base address B for the latched zone from package tables SIZE[] and BASE[].
REQ-006 SHALL define the box as x_l <= pixel_x <= x_l+N-1 and y_l <= pixel_y <= y_l+N-1, compared at COORD_W+1 bits so that x_l+N or y_l+N overflow never wraps.
REQ-007 SHALL keep a row_offset register:
- cleared on frame_start, reset, or any pix_valid with pixel_y < y_l
- incremented by N when pixel_y differs from the previously registered pixel_y and pixel_y lies in (y_l, y_l+N-1]
- held otherwise
REQ-008 SHALL drive rom_addr = B + row_offset + (pixel_x - x_l), registered one cycle after pix_valid; rom_addr is 0 when the pixel is outside the box.
REQ-009 SHALL produce color, color_valid and active exactly 3 cycles after the pix_valid cycle, with no bubbles and one result per valid input.
REQ-010 SHALL set active = in_box AND rom_data[KEY_HI:KEY_LO] >= KEY_THRESH; color = rom_data when active, else 0.
REQ-011 SHALL apply frame_start coincident with pix_valid first, so that pixel uses the new latched values.

Reset
REQ-012 SHALL on rst low asynchronously clear color, color_valid, active, rom_addr, row_offset, zone, latched locations, registered pixel_y and all pipeline valids to 0.
REQ-013 SHALL discard in-flight pixels on reset mid-operation; the first color_valid after release comes 3 cycles after the first post-reset pix_valid.

Configuration
REQ-014 SHALL, with DEPTH_SPRITE_MIRROR_EN defined, add input mirror (1 bit, latched on frame_start) and use column N-1-(pixel_x - x_l) when mirror=1.
REQ-015 SHALL, without DEPTH_SPRITE_MIRROR_EN, have no mirror port and always use column (pixel_x - x_l).

Structure
REQ-016 SHALL place SIZE[], BASE[], the ZONE_STEP default and KEY_THRESH in shared package sprite_pkg.
REQ-017 SHALL implement zone quantise/clamp plus table lookup as sub-module depth_zone_lut, with the box/offset/pipeline logic in depth_sprite.

Verification
REQ-018 Bench SHALL cover:
- z_loc=0, loc=(100,50), pixel (100,50) valid -> rom_addr=BASE[0] next cycle; color=rom_data 3 cycles after input if key>=0x90
- z_loc=975 -> zone 19; z_loc=60000 -> zone 19 (clamp)
- zone 0 (N=69), pixel (102,52) after rows 50/51 -> rom_addr=BASE[0]+2*69+2
- rom_data key 0x8F in box -> color=0, active=0, color_valid=1
- x_loc changed mid-frame -> box unchanged until next frame_start
- rst low with 3 pixels in flight -> outputs 0 immediately; no stale color_valid after release

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite constants: per-zone sprite side (SIZE) and ROM base address (BASE) tables,
// plus default zone step and transparency key threshold.
package sprite_pkg;

    localparam int NUM_ZONES_MAX = 20;
    localparam int DFLT_ZONE_STEP = 50;
    localparam logic [7:0] DFLT_KEY_THRESH = 8'h90;

    // Each BASE entry is the running sum of SIZE^2 for the zones before it.
    localparam logic [7:0] SIZE [NUM_ZONES_MAX] = '{
        8'd69, 8'd56, 8'd46, 8'd38, 8'd32, 8'd27, 8'd23, 8'd20, 8'd18, 8'd16,
        8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9,  8'd8,  8'd8,  8'd7,  8'd6
    };

    localparam logic [13:0] BASE [NUM_ZONES_MAX] = '{
        14'd0,     14'd4761,  14'd7897,  14'd10013, 14'd11457,
        14'd12481, 14'd13210, 14'd13739, 14'd14139, 14'd14463,
        14'd14719, 14'd14915, 14'd15084, 14'd15228, 14'd15349,
        14'd15449, 14'd15530, 14'd15594, 14'd15658, 14'd15707
    };

endpackage

// File: rtl/depth_zone_lut.sv
// Quantises z_loc into a clamped depth zone, holds it from frame_start to frame_start,
// and looks up the sprite side and ROM base for that zone.
module depth_zone_lut
    import sprite_pkg::*;
#(
    parameter int COORD_W   = 16,
    parameter int NUM_ZONES = 20,
    parameter int ZONE_STEP = DFLT_ZONE_STEP,
    parameter int ADDR_W    = 14,
    localparam int ZONE_W   = $clog2(NUM_ZONES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [COORD_W-1:0] i_z_loc,
    output logic [COORD_W-1:0] o_size,
    output logic [ADDR_W-1:0]  o_base
);

    logic [COORD_W-1:0] w_quot;
    logic [ZONE_W-1:0]  w_zone_new;
    logic [ZONE_W-1:0]  w_zone;
    logic [ZONE_W-1:0]  r_zone;

    assign w_quot     = i_z_loc / COORD_W'(ZONE_STEP);
    assign w_zone_new = (w_quot >= COORD_W'(NUM_ZONES - 1)) ? ZONE_W'(NUM_ZONES - 1)
                                                             : w_quot[ZONE_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_zone <= '0;
        end else if (i_load) begin
            r_zone <= w_zone_new;
        end
    end

    // A pixel arriving together with frame_start must already see the new zone.
    assign w_zone = i_load ? w_zone_new : r_zone;
    assign o_size = COORD_W'(SIZE[w_zone]);
    assign o_base = ADDR_W'(BASE[w_zone]);

endmodule

// File: rtl/depth_sprite.sv
// Depth-scaled sprite renderer: box test, row offset tracking, ROM addressing and a 3-cycle
// colour pipeline. Optional horizontal mirroring is enabled by defining DEPTH_SPRITE_MIRROR_EN.
module depth_sprite
    import sprite_pkg::*;
#(
    parameter int COORD_W   = 16,
    parameter int COLOR_W   = 24,
    parameter int NUM_ZONES = 20,
    parameter int ZONE_STEP = DFLT_ZONE_STEP,
    parameter int ADDR_W    = 14,
    parameter int KEY_HI    = 15,
    parameter int KEY_LO    = 8,
    parameter logic [KEY_HI-KEY_LO:0] KEY_THRESH = DFLT_KEY_THRESH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [COORD_W-1:0] x_loc,
    input  logic [COORD_W-1:0] y_loc,
    input  logic [COORD_W-1:0] z_loc,
`ifdef DEPTH_SPRITE_MIRROR_EN
    input  logic               mirror,
`endif
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] color,
    output logic               color_valid,
    output logic               active
);

    logic [COORD_W-1:0] r_x_l, r_y_l, r_pix_y;
    logic [COORD_W-1:0] w_x_l, w_y_l, w_size, w_col, w_col_eff;
    logic [COORD_W:0]   w_px, w_py, w_xl, w_yl, w_n;
    logic [ADDR_W-1:0]  w_base, w_addr, w_row_next, r_row_offset;
    logic               w_in_box, w_new_row, w_active;
    logic               r_v1, r_in1, r_v2, r_in2;

    assign w_x_l = frame_start ? x_loc : r_x_l;
    assign w_y_l = frame_start ? y_loc : r_y_l;

    depth_zone_lut #(
        .COORD_W   (COORD_W),
        .NUM_ZONES (NUM_ZONES),
        .ZONE_STEP (ZONE_STEP),
        .ADDR_W    (ADDR_W)
    ) u_zone_lut (
        .clk     (clk),
        .rst     (rst),
        .i_load  (frame_start),
        .i_z_loc (z_loc),
        .o_size  (w_size),
        .o_base  (w_base)
    );

    // One extra bit keeps x_l+N and y_l+N from wrapping near the top of the coordinate range.
    assign w_px = {1'b0, pixel_x};
    assign w_py = {1'b0, pixel_y};
    assign w_xl = {1'b0, w_x_l};
    assign w_yl = {1'b0, w_y_l};
    assign w_n  = {1'b0, w_size};

    assign w_in_box  = (w_px >= w_xl) && (w_px < w_xl + w_n) &&
                       (w_py >= w_yl) && (w_py < w_yl + w_n);
    assign w_new_row = (pixel_y != r_pix_y) && (w_py > w_yl) && (w_py < w_yl + w_n);
    assign w_col     = pixel_x - w_x_l;

`ifdef DEPTH_SPRITE_MIRROR_EN
    logic r_mirror, w_mirror;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mirror <= 1'b0;
        end else if (frame_start) begin
            r_mirror <= mirror;
        end
    end

    assign w_mirror  = frame_start ? mirror : r_mirror;
    assign w_col_eff = w_mirror ? (w_size - COORD_W'(1) - w_col) : w_col;
`else
    assign w_col_eff = w_col;
`endif

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        w_row_next = r_row_offset;
        if (frame_start) begin
            w_row_next = '0;
        end
        if (pix_valid) begin
            if (w_py < w_yl) begin
                w_row_next = '0;
            end else if (w_new_row) begin
                w_row_next = w_row_next + ADDR_W'(w_size);
            end
        end
    end

    // The current pixel already uses the offset of its own row.
    assign w_addr   = w_base + w_row_next + w_col_eff[ADDR_W-1:0];
    assign w_active = r_in2 && (rom_data[KEY_HI:KEY_LO] >= KEY_THRESH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_l        <= '0;
            r_y_l        <= '0;
            r_pix_y      <= '0;
            r_row_offset <= '0;
            rom_addr     <= '0;
            r_v1         <= 1'b0;
            r_in1        <= 1'b0;
            r_v2         <= 1'b0;
            r_in2        <= 1'b0;
            color        <= '0;
            color_valid  <= 1'b0;
            active       <= 1'b0;
        end else begin
            if (frame_start) begin
                r_x_l <= x_loc;
                r_y_l <= y_loc;
            end
            if (pix_valid) begin
                r_pix_y <= pixel_y;
            end
            r_row_offset <= w_row_next;
            rom_addr     <= (pix_valid && w_in_box) ? w_addr : '0;
            r_v1         <= pix_valid;
            r_in1        <= pix_valid && w_in_box;
            // Stage 2 lines up with the ROM's one-cycle read latency.
            r_v2         <= r_v1;
            r_in2        <= r_in1;
            color_valid  <= r_v2;
            active       <= w_active;
            color        <= w_active ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_depth_sprite.sv
// Directed self-checking bench for depth_sprite with a synchronous ROM model.
`timescale 1ns/1ps
module tb_depth_sprite;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pixel_x = '0, pixel_y = '0;
    logic [15:0] x_loc = '0, y_loc = '0, z_loc = '0;
    logic [13:0] rom_addr;
    logic [23:0] rom_data;
    logic [23:0] color;
    logic        color_valid, active;
`ifdef DEPTH_SPRITE_MIRROR_EN
    logic        mirror = 1'b0;
`endif

    logic [23:0] rom_mem [16384];
    int n_checks = 0;
    int n_fail = 0;

    depth_sprite dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .x_loc       (x_loc),
        .y_loc       (y_loc),
        .z_loc       (z_loc),
`ifdef DEPTH_SPRITE_MIRROR_EN
        .mirror      (mirror),
`endif
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .color       (color),
        .color_valid (color_valid),
        .active      (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic set_loc(input int x, input int y, input int z);
        x_loc = 16'(x);
        y_loc = 16'(y);
        z_loc = 16'(z);
    endtask

    // Drives one pixel at a negedge and returns at the next negedge with pix_valid low.
    task automatic send(input bit fs, input int x, input int y);
        frame_start = fs;
        pix_valid   = 1'b1;
        pixel_x     = 16'(x);
        pixel_y     = 16'(y);
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL reset rom_addr: got %0d want 0", rom_addr); end
        n_checks++; if (color !== 24'd0) begin n_fail++; $display("FAIL reset color: got %0h want 0", color); end
        n_checks++; if (color_valid !== 1'b0) begin n_fail++; $display("FAIL reset color_valid: got %b want 0", color_valid); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset active: got %b want 0", active); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_loc(100, 50, 0);
        send(1'b1, 100, 50);
        n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL basic rom_addr: got %0d want 0", rom_addr); end
        @(negedge clk); @(negedge clk);
        n_checks++; if (color_valid !== 1'b1) begin n_fail++; $display("FAIL basic color_valid: got %b want 1", color_valid); end
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL basic active: got %b want 1", active); end
        n_checks++; if (color !== rom_mem[0]) begin n_fail++; $display("FAIL basic color: got %0h want %0h", color, rom_mem[0]); end
        send(1'b0, 105, 50);
        n_checks++; if (rom_addr !== 14'd5) begin n_fail++; $display("FAIL basic col5 rom_addr: got %0d want 5", rom_addr); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_zone_clamp();
        int zs [5] = '{975, 60000, 949, 50, 49};
        int ex [5] = '{15708, 15708, 15659, 4762, 1};
        for (int i = 0; i < 5; i++) begin
            set_loc(100, 50, zs[i]);
            send(1'b1, 101, 50);
            n_checks++;
            if (rom_addr !== 14'(ex[i])) begin
                n_fail++;
                $display("FAIL zone z=%0d rom_addr: got %0d want %0d", zs[i], rom_addr, ex[i]);
            end
        end
        // Zone 19 box edges (N=6).
        set_loc(100, 50, 975);
        send(1'b1, 105, 50);
        n_checks++; if (rom_addr !== 14'd15712) begin n_fail++; $display("FAIL zone19 right edge: got %0d want 15712", rom_addr); end
        send(1'b0, 106, 50);
        n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL zone19 past right: got %0d want 0", rom_addr); end
        send(1'b0, 105, 55);
        n_checks++; if (rom_addr !== 14'd15718) begin n_fail++; $display("FAIL zone19 bottom row: got %0d want 15718", rom_addr); end
        send(1'b0, 100, 56);
        n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL zone19 past bottom: got %0d want 0", rom_addr); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_row_offset();
        int xs [11] = '{101, 168, 169, 100, 101, 102,  99, 103, 100, 105, 100};
        int ys [11] = '{ 50,  50,  50,  51,  51,  52,  52,  52,  49,  50,  51};
        int ex [11] = '{  1,  68,   0,  69,  70, 140,   0, 141,   0,   5,  69};
        set_loc(100, 50, 0);
        for (int i = 0; i < 11; i++) begin
            frame_start = (i == 0);
            pix_valid   = 1'b1;
            pixel_x     = 16'(xs[i]);
            pixel_y     = 16'(ys[i]);
            @(negedge clk);
            n_checks++;
            if (rom_addr !== 14'(ex[i])) begin
                n_fail++;
                $display("FAIL row_offset (%0d,%0d): got %0d want %0d", xs[i], ys[i], rom_addr, ex[i]);
            end
        end
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_key();
        set_loc(100, 50, 0);
        send(1'b1, 103, 50);
        n_checks++; if (rom_addr !== 14'd3) begin n_fail++; $display("FAIL key rom_addr: got %0d want 3", rom_addr); end
        @(negedge clk); @(negedge clk);
        n_checks++; if (color_valid !== 1'b1) begin n_fail++; $display("FAIL key 8F color_valid: got %b want 1", color_valid); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL key 8F active: got %b want 0", active); end
        n_checks++; if (color !== 24'd0) begin n_fail++; $display("FAIL key 8F color: got %0h want 0", color); end
        send(1'b0, 100, 50);
        @(negedge clk); @(negedge clk);
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL key 90 active: got %b want 1", active); end
        n_checks++; if (color !== 24'h009000) begin n_fail++; $display("FAIL key 90 color: got %0h want 009000", color); end
    endtask

    task automatic test_midframe();
        set_loc(100, 50, 0);
        send(1'b1, 150, 50);
        n_checks++; if (rom_addr !== 14'd50) begin n_fail++; $display("FAIL midframe start: got %0d want 50", rom_addr); end
        set_loc(200, 0, 975);
        send(1'b0, 151, 50);
        n_checks++; if (rom_addr !== 14'd51) begin n_fail++; $display("FAIL midframe held box: got %0d want 51", rom_addr); end
        send(1'b1, 150, 50);
        n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL midframe new box out: got %0d want 0", rom_addr); end
        @(negedge clk); @(negedge clk);
        n_checks++; if (color_valid !== 1'b1) begin n_fail++; $display("FAIL midframe out color_valid: got %b want 1", color_valid); end
        n_checks++; if (active !== 1'b0 || color !== 24'd0) begin n_fail++; $display("FAIL midframe out active/color: got %b/%0h want 0/0", active, color); end
        send(1'b0, 201, 0);
        n_checks++; if (rom_addr !== 14'd15708) begin n_fail++; $display("FAIL midframe new box in: got %0d want 15708", rom_addr); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_overflow();
        set_loc(65500, 50, 0);
        send(1'b1, 65535, 50);
        n_checks++; if (rom_addr !== 14'd35) begin n_fail++; $display("FAIL overflow x top: got %0d want 35", rom_addr); end
        send(1'b0, 10, 50);
        n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL overflow x wrap: got %0d want 0", rom_addr); end
        set_loc(100, 65530, 0);
        send(1'b1, 101, 65530);
        n_checks++; if (rom_addr !== 14'd1) begin n_fail++; $display("FAIL overflow y first: got %0d want 1", rom_addr); end
        send(1'b0, 101, 65531);
        n_checks++; if (rom_addr !== 14'd70) begin n_fail++; $display("FAIL overflow y second: got %0d want 70", rom_addr); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          xs [4]     = '{100, 103, 200, 110};
        int          ea [4]     = '{0, 3, 0, 10};
        logic        e_act [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [23:0] e_col;
        int          k;
        repeat (3) @(negedge clk);
        set_loc(100, 50, 0);
        for (int c = 0; c < 7; c++) begin
            frame_start = (c == 0);
            pix_valid   = (c < 4);
            pixel_x     = (c < 4) ? 16'(xs[c]) : 16'd0;
            pixel_y     = 16'd50;
            @(negedge clk);
            if (c < 4) begin
                n_checks++;
                if (rom_addr !== 14'(ea[c])) begin n_fail++; $display("FAIL b2b rom_addr[%0d]: got %0d want %0d", c, rom_addr, ea[c]); end
            end
            k = c - 2;
            if (k >= 0 && k < 4) begin
                e_col = e_act[k] ? rom_mem[ea[k]] : 24'd0;
                n_checks++;
                if (color_valid !== 1'b1 || active !== e_act[k] || color !== e_col) begin
                    n_fail++;
                    $display("FAIL b2b out[%0d]: got v=%b a=%b c=%0h want v=1 a=%b c=%0h", k, color_valid, active, color, e_act[k], e_col);
                end
            end else begin
                n_checks++;
                if (color_valid !== 1'b0) begin n_fail++; $display("FAIL b2b idle cycle %0d color_valid: got %b want 0", c, color_valid); end
            end
        end
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic test_reset_inflight();
        set_loc(100, 50, 0);
        for (int i = 0; i < 3; i++) begin
            frame_start = (i == 0);
            pix_valid   = 1'b1;
            pixel_x     = 16'(101 + i);
            pixel_y     = 16'd50;
            @(negedge clk);
        end
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        n_checks++; if (color_valid !== 1'b1) begin n_fail++; $display("FAIL inflight pre-reset color_valid: got %b want 1", color_valid); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (color_valid !== 1'b0) begin n_fail++; $display("FAIL inflight reset color_valid: got %b want 0", color_valid); end
        n_checks++; if (color !== 24'd0 || active !== 1'b0) begin n_fail++; $display("FAIL inflight reset color/active: got %0h/%b want 0/0", color, active); end
        n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL inflight reset rom_addr: got %0d want 0", rom_addr); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (color_valid !== 1'b0) begin n_fail++; $display("FAIL post-reset stale color_valid cycle %0d: got %b want 0", i, color_valid); end
        end
        // Latched location and zone were cleared, so the box is (0,0) with N=69.
        send(1'b0, 5, 0);
        n_checks++; if (rom_addr !== 14'd5) begin n_fail++; $display("FAIL post-reset rom_addr: got %0d want 5", rom_addr); end
        @(negedge clk);
        n_checks++; if (color_valid !== 1'b0) begin n_fail++; $display("FAIL post-reset early color_valid: got %b want 0", color_valid); end
        @(negedge clk);
        n_checks++; if (color_valid !== 1'b1) begin n_fail++; $display("FAIL post-reset color_valid: got %b want 1", color_valid); end
        n_checks++; if (color !== rom_mem[5]) begin n_fail++; $display("FAIL post-reset color: got %0h want %0h", color, rom_mem[5]); end
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) begin
            logic [13:0] aa;
            aa = 14'(a);
            rom_mem[a] = {aa[13:6], 8'h90 | {2'b00, aa[5:0]}, aa[7:0]};
        end
        rom_mem[3][15:8] = 8'h8F;

        test_reset();
        test_basic();
        test_zone_clamp();
        test_row_offset();
        test_key();
        test_midframe();
        test_overflow();
        test_back_to_back();
        test_reset_inflight();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
